synapse_integrator: RTL and testbench

- Upstream stage for the LIF neuron.
- Converts N_IN presynaptic spike lines into the 8-bit unsigned synaptic current `isyn` that drives a neuron's `Isyn` input.
- Holds a programmable bank of signed weights and sums the weights of active spikes each cycle.
- Applies periodic leaky decay to the current and saturates the result to 0..255.

---
 rtl/snn_pkg.sv | 10 +
 rtl/syn_weight_bank.sv | 23 ++
 rtl/synapse_integrator.sv | 54 +++++
 tb/tb_synapse_integrator.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/snn_pkg.sv
// snn_pkg: shared widths, weight type and unsigned saturation for the SNN datapath
package snn_pkg;
  localparam int ISYN_W = 8;
  localparam int WEIGHT_W = 8;
  localparam int ACC_MAX_W = 16;
  typedef logic signed [WEIGHT_W-1:0] weight_t;
  function automatic logic [ISYN_W-1:0] sat_u8(input logic signed [ACC_MAX_W-1:0] a);
    return (a < 0) ? '0 : (a > 16'sd255) ? '1 : a[ISYN_W-1:0];
  endfunction
endpackage

// File: rtl/syn_weight_bank.sv
// syn_weight_bank: N_IN signed weights, one write port, all weights readable in parallel
//   clk, rst_n : clock, asynchronous active-low reset (weights return to WEIGHT_RST)
//   we/addr/data : write strobe, index, signed value; indices >= N_IN are ignored
//   weights    : every weight, combinationally visible
module syn_weight_bank import snn_pkg::*; #(
  parameter int N_IN = 4,
  parameter weight_t WEIGHT_RST = 8'sd16,
  localparam int AW = (N_IN > 1) ? $clog2(N_IN) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  weight_t       data,
  output weight_t       weights [N_IN]
);
  // per-entry address match leaves out-of-range indices with no target
  for (genvar i = 0; i < N_IN; i++) begin : g_w
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) weights[i] <= WEIGHT_RST;
      else if (we && addr == AW'(i)) weights[i] <= data;
  end
endmodule

// File: rtl/synapse_integrator.sv
// synapse_integrator: sums weights of registered spikes into a leaky, saturating 8-bit current
//   clk, rst_n : clock, asynchronous active-low reset
//   ena        : advance enable; low holds spike register, decay counter and isyn
//   pre_spike  : presynaptic spike levels
//   wt_we/wt_addr/wt_data : weight write port, active regardless of ena
//   isyn       : registered synaptic current 0..255
module synapse_integrator import snn_pkg::*; #(
  parameter int N_IN = 4,
  parameter int DECAY_SHIFT = 3,
  parameter int DECAY_PERIOD = 4,
  parameter weight_t WEIGHT_RST = 8'sd16,
  localparam int AW = (N_IN > 1) ? $clog2(N_IN) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic [N_IN-1:0]   pre_spike,
  input  logic              wt_we,
  input  logic [AW-1:0]     wt_addr,
  input  logic [7:0]        wt_data,
  output logic [ISYN_W-1:0] isyn
);
  // wide enough for N_IN full-scale weights plus isyn and sign, so only the result clamps
  localparam int ACC_W = WEIGHT_W + $clog2(N_IN) + 2;
  localparam int DCW = (DECAY_PERIOD > 1) ? $clog2(DECAY_PERIOD) : 1;
  logic [N_IN-1:0] spk_q;
  logic [DCW-1:0] dcnt;
  weight_t weights [N_IN];
  logic signed [ACC_W-1:0] sum, acc;
  logic [ISYN_W-1:0] shr, dec;
  logic tick;
  syn_weight_bank #(.N_IN(N_IN), .WEIGHT_RST(WEIGHT_RST)) u_bank (
    .clk(clk), .rst_n(rst_n), .we(wt_we), .addr(wt_addr), .data(wt_data), .weights(weights)
  );
  always_comb begin
    sum = '0;
    for (int i = 0; i < N_IN; i++) sum += spk_q[i] ? ACC_W'(weights[i]) : '0;
  end
  assign tick = ena && dcnt == DCW'(DECAY_PERIOD - 1);
  assign shr = isyn >> DECAY_SHIFT;
  // a floor of 1 keeps small currents draining all the way to zero
  assign dec = (tick && isyn != '0) ? ((shr == '0) ? ISYN_W'(1) : shr) : '0;
  assign acc = $signed(ACC_W'(isyn)) - $signed(ACC_W'(dec)) + sum;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      spk_q <= '0;
      dcnt <= '0;
      isyn <= '0;
    end else if (ena) begin
      spk_q <= pre_spike;
      dcnt <= tick ? '0 : dcnt + 1'b1;
      isyn <= sat_u8(ACC_MAX_W'(acc));
    end
endmodule

// File: tb/tb_synapse_integrator.sv
// tb_synapse_integrator: directed and random stimulus checked against a cycle-level behavioural model
module tb_synapse_integrator;
  logic clk = 0, rst_n = 0, ena = 0, wt_we = 0;
  logic [3:0] pre_spike = '0;
  logic [1:0] wt_addr = '0;
  logic [7:0] wt_data = '0, isyn;
  logic ena6 = 0, we6 = 0;
  logic [5:0] spk6 = '0;
  logic [2:0] addr6 = '0;
  logic [7:0] data6 = '0, isyn6;
  int tests = 0, fails = 0;
  int w [4];
  int m_isyn, ecnt, n, held;
  logic [3:0] m_spk;

  always #5 clk = ~clk;

  synapse_integrator dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .pre_spike(pre_spike), .wt_we(wt_we),
    .wt_addr(wt_addr), .wt_data(wt_data), .isyn(isyn)
  );

  // six inputs give a 3-bit address, so indices past the bank can be driven
  synapse_integrator #(.N_IN(6), .DECAY_PERIOD(1000)) dut6 (
    .clk(clk), .rst_n(rst_n), .ena(ena6), .pre_spike(spk6), .wt_we(we6),
    .wt_addr(addr6), .wt_data(data6), .isyn(isyn6)
  );

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: isyn=%0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) w[i] = 16;
    m_isyn = 0;
    ecnt = 0;
    m_spk = '0;
  endtask

  // one clock of the specified behaviour, in integer arithmetic
  task automatic model_step(input logic [3:0] s, input logic e, input logic wr, input logic [1:0] a, input logic [7:0] d);
    int sum, dec;
    if (e) begin
      sum = 0;
      dec = 0;
      for (int i = 0; i < 4; i++) if (m_spk[i]) sum += w[i];
      if (ecnt % 4 == 3 && m_isyn > 0) dec = (m_isyn / 8 > 0) ? m_isyn / 8 : 1;
      m_isyn = m_isyn - dec + sum;
      if (m_isyn < 0) m_isyn = 0;
      else if (m_isyn > 255) m_isyn = 255;
      ecnt++;
      m_spk = s;
    end
    if (wr) w[a] = int'($signed(d));
  endtask

  task automatic step(input string tag, input logic [3:0] s, input logic e, input logic wr, input logic [1:0] a, input logic [7:0] d);
    pre_spike = s; ena = e; wt_we = wr; wt_addr = a; wt_data = d;
    @(posedge clk);
    model_step(s, e, wr, a, d);
    #1 check(tag, isyn, 8'(m_isyn));
    @(negedge clk);
  endtask

  // reset asserted between edges, so a cleared isyn proves it is asynchronous
  task automatic do_reset();
    #2 rst_n = 0;
    #1 model_reset();
    check("async_reset", isyn, 8'd0);
    @(negedge clk);
    rst_n = 1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    model_reset();
    #1 check("reset_init", isyn, 8'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;
    we6 = 1; addr6 = 3'd7; data6 = 8'd100;
    @(negedge clk);
    addr6 = 3'd6;
    @(negedge clk);
    we6 = 0; ena6 = 1; spk6 = '1;
    @(negedge clk);
    spk6 = '0;
    @(negedge clk);
    ena6 = 0;
    check("oob_write_ignored", isyn6, 8'd96);
    repeat (20) step("idle_zero", 4'd0, 1, 0, 0, 0);
    do_reset();
    repeat (5) step("pre_spike", 4'd0, 1, 0, 0, 0);
    step("spike0", 4'b0001, 1, 0, 0, 0);
    step("latency", 4'd0, 1, 0, 0, 0);
    check("single_16", isyn, 8'd16);
    n = 0;
    while (isyn !== 8'd0 && n < 100) begin
      step("decay", 4'd0, 1, 0, 0, 0);
      n++;
    end
    tests++;
    assert (n === 57) else begin
      fails++;
      $error("FAIL decay_to_zero: cycles=%0d expected 57", n);
    end
    for (int i = 0; i < 4; i++) step("wr127", 4'd0, 1, 1, 2'(i), 8'd127);
    step("burst1", 4'b1111, 1, 0, 0, 0);
    step("burst1_add", 4'd0, 1, 0, 0, 0);
    check("sat_255", isyn, 8'd255);
    step("burst2", 4'b1111, 1, 0, 0, 0);
    step("burst2_add", 4'd0, 1, 0, 0, 0);
    check("sat_hold_255", isyn, 8'd255);
    do_reset();
    step("wr_w0_100", 4'd0, 1, 1, 2'd0, 8'd100);
    step("spk_w0", 4'b0001, 1, 0, 0, 0);
    step("add_100", 4'd0, 1, 0, 0, 0);
    check("isyn_100", isyn, 8'd100);
    step("wr_w1_m128", 4'b0010, 1, 1, 2'd1, 8'h80);
    step("inhib", 4'd0, 1, 0, 0, 0);
    check("clamp_zero", isyn, 8'd0);
    step("wr_w0_50", 4'd0, 1, 1, 2'd0, 8'd50);
    step("wr_w1_m30", 4'd0, 1, 1, 2'd1, 8'hE2);
    step("spk_both", 4'b0011, 1, 0, 0, 0);
    step("cancel", 4'd0, 1, 0, 0, 0);
    check("cancel_20", isyn, 8'd20);
    do_reset();
    step("spk2", 4'b0100, 1, 0, 0, 0);
    step("wr_w2_same", 4'd0, 1, 1, 2'd2, 8'd64);
    check("old_weight_16", isyn, 8'd16);
    step("spk2_again", 4'b0100, 1, 0, 0, 0);
    step("new_weight", 4'd0, 1, 0, 0, 0);
    check("new_weight_78", isyn, 8'd78);
    held = isyn;
    for (int i = 0; i < 10; i++) begin
      step("freeze", 4'($urandom), 0, i == 4, 2'd3, 8'hFB);
      check("frozen", isyn, 8'(held));
    end
    repeat (8) step("resume", 4'($urandom), 1, 0, 0, 0);
    step("burst_a", 4'b1111, 1, 0, 0, 0);
    step("burst_b", 4'b1111, 1, 0, 0, 0);
    do_reset();
    step("discard", 4'b0001, 1, 0, 0, 0);
    check("inflight_dropped", isyn, 8'd0);
    step("w_rst", 4'd0, 1, 0, 0, 0);
    check("weight_back_16", isyn, 8'd16);
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 99) == 0) do_reset();
      step("random", 4'($urandom), $urandom_range(0, 3) != 0, $urandom_range(0, 4) == 0,
           2'($urandom), 8'($urandom));
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
